// File: rtl/lc4_dual_issue_sched_pkg.sv
// Shared definitions for the LC4 dual-issue scheduler: stall-cause codes,
// load-latency bound and the packed scoreboard type.
package lc4_ss_pkg;

  localparam int LOAD_LAT_MAX = 3;
  localparam int NUM_REGS     = 8;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_DEP      = 2'd2,
    CAUSE_STRUCT   = 2'd3
  } stall_cause_e;

  typedef logic [NUM_REGS-1:0][1:0] busy_vec_t;

  // An enabled source is blocked while its scoreboard counter is non-zero.
  function automatic logic src_busy(input busy_vec_t busy, input logic [2:0] r, input logic en);
    return en && (busy[r] != 2'd0);
  endfunction

endpackage

// File: rtl/lc4_dual_issue_sched_hazard_chk.sv
// Hazard check for one issue slot. FULL=0 gives the scoreboard-only check
// used by the older slot; FULL=1 adds intra-pair dependence and structural checks.
module lc4_hazard_chk
  import lc4_ss_pkg::*;
#(
  parameter bit FULL = 1'b1
) (
  input  busy_vec_t  i_busy,
  input  logic       i_vld,
  input  logic [2:0] i_rs,
  input  logic [2:0] i_rt,
  input  logic       i_rs_re,
  input  logic       i_rt_re,
  input  logic       i_is_mem,
  input  logic [2:0] i_old_rd,
  input  logic       i_old_rd_we,
  input  logic       i_old_is_mem,
  input  logic       i_old_is_br,
  output logic       o_hz_sb,
  output logic       o_hz_dep,
  output logic       o_hz_struct
);

  logic w_dep;
  logic w_struct;

  assign w_dep = i_old_rd_we &&
                 ((i_rs_re && (i_rs == i_old_rd)) || (i_rt_re && (i_rt == i_old_rd)));
  // A write-after-write on the same rd is deliberately not a hazard.
  assign w_struct = (i_old_is_mem && i_is_mem) || i_old_is_br;

  assign o_hz_sb     = i_vld && (src_busy(i_busy, i_rs, i_rs_re) || src_busy(i_busy, i_rt, i_rt_re));
  assign o_hz_dep    = FULL && i_vld && w_dep;
  assign o_hz_struct = FULL && i_vld && w_struct;

endmodule

// File: rtl/lc4_dual_issue_sched.sv
// LC4 two-slot in-order issue scheduler with a load scoreboard.
// Optional performance counters are enabled with macro LC4_SS_PERF_CNT_EN.
module lc4_dual_issue_sched
  import lc4_ss_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        i_flush,
  input  logic        i_vld_A,
  input  logic        i_vld_B,
  input  logic [2:0]  i_rs_A,
  input  logic [2:0]  i_rt_A,
  input  logic [2:0]  i_rd_A,
  input  logic [2:0]  i_rs_B,
  input  logic [2:0]  i_rt_B,
  input  logic [2:0]  i_rd_B,
  input  logic        i_rs_re_A,
  input  logic        i_rt_re_A,
  input  logic        i_rd_we_A,
  input  logic        i_rs_re_B,
  input  logic        i_rt_re_B,
  input  logic        i_rd_we_B,
  input  logic        i_is_mem_A,
  input  logic        i_is_load_A,
  input  logic        i_is_br_A,
  input  logic        i_is_mem_B,
  input  logic        i_is_load_B,
  input  logic        i_is_br_B,
  output logic        o_issue_A,
  output logic        o_issue_B,
  output logic [1:0]  o_advance,
  output logic [1:0]  o_stall_cause
`ifdef LC4_SS_PERF_CNT_EN
  ,
  output logic [31:0] o_cnt_dual,
  output logic [31:0] o_cnt_single,
  output logic [31:0] o_cnt_stall
`endif
);

  localparam logic [1:0] LAT_ENC = (LOAD_LAT > LOAD_LAT_MAX) ? 2'(LOAD_LAT_MAX) :
                                   (LOAD_LAT < 1)            ? 2'd1 : 2'(LOAD_LAT);

  busy_vec_t        r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic             w_sb_A, w_dep_A, w_st_A;
  logic             w_sb_B, w_dep_B, w_st_B;
  logic             w_hz_A, w_hz_B;
  logic             w_issue_A, w_issue_B;
  stall_cause_e     w_cause;

  lc4_hazard_chk #(.FULL(1'b0)) u_chk_A (
    .i_busy       (r_busy),
    .i_vld        (i_vld_A),
    .i_rs         (i_rs_A),
    .i_rt         (i_rt_A),
    .i_rs_re      (i_rs_re_A),
    .i_rt_re      (i_rt_re_A),
    .i_is_mem     (i_is_mem_A),
    .i_old_rd     (3'd0),
    .i_old_rd_we  (1'b0),
    .i_old_is_mem (1'b0),
    .i_old_is_br  (1'b0),
    .o_hz_sb      (w_sb_A),
    .o_hz_dep     (w_dep_A),
    .o_hz_struct  (w_st_A)
  );

  lc4_hazard_chk #(.FULL(1'b1)) u_chk_B (
    .i_busy       (r_busy),
    .i_vld        (i_vld_B),
    .i_rs         (i_rs_B),
    .i_rt         (i_rt_B),
    .i_rs_re      (i_rs_re_B),
    .i_rt_re      (i_rt_re_B),
    .i_is_mem     (i_is_mem_B),
    .i_old_rd     (i_rd_A),
    .i_old_rd_we  (i_rd_we_A),
    .i_old_is_mem (i_is_mem_A),
    .i_old_is_br  (i_is_br_A),
    .o_hz_sb      (w_sb_B),
    .o_hz_dep     (w_dep_B),
    .o_hz_struct  (w_st_B)
  );

  assign w_hz_A = w_sb_A | w_dep_A | w_st_A;
  assign w_hz_B = w_sb_B | w_dep_B | w_st_B;

  // Reset forces all outputs low combinationally, not just at the next edge.
  assign w_issue_A = rst & i_vld_A & ~w_hz_A & ~i_flush;
  assign w_issue_B = w_issue_A & i_vld_B & ~w_hz_B;

  always_comb begin
    w_cause = CAUSE_NONE;
    if (!rst) begin
      w_cause = CAUSE_NONE;
    end else if (i_vld_A && !w_issue_A) begin
      if (w_sb_A)       w_cause = CAUSE_LOAD_USE;
      else if (w_dep_A) w_cause = CAUSE_DEP;
      else if (w_st_A)  w_cause = CAUSE_STRUCT;
      else              w_cause = CAUSE_NONE;
    end else if (w_issue_A && i_vld_B && !w_issue_B) begin
      if (w_sb_B)       w_cause = CAUSE_LOAD_USE;
      else if (w_dep_B) w_cause = CAUSE_DEP;
      else if (w_st_B)  w_cause = CAUSE_STRUCT;
      else              w_cause = CAUSE_NONE;
    end else begin
      w_cause = CAUSE_NONE;
    end
  end

  assign o_issue_A     = w_issue_A;
  assign o_issue_B     = w_issue_B;
  assign o_advance     = {1'b0, w_issue_A} + {1'b0, w_issue_B};
  assign o_stall_cause = w_cause;

  // Both slots loading the same rd simply OR into one set bit.
  always_comb begin
    w_set = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_set[r] = (w_issue_A && i_is_load_A && i_rd_we_A && (i_rd_A == 3'(r))) ||
                 (w_issue_B && i_is_load_B && i_rd_we_B && (i_rd_B == 3'(r)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (gwe) begin
      if (i_flush) begin
        r_busy <= '0;
      end else begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (w_set[r])                 r_busy[r] <= LAT_ENC;
          else if (r_busy[r] != 2'd0)   r_busy[r] <= r_busy[r] - 2'd1;
        end
      end
    end
  end

`ifdef LC4_SS_PERF_CNT_EN
  logic [31:0] r_cnt_dual;
  logic [31:0] r_cnt_single;
  logic [31:0] r_cnt_stall;

  // Stall cycles are counted only when there was an instruction waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_dual   <= 32'd0;
      r_cnt_single <= 32'd0;
      r_cnt_stall  <= 32'd0;
    end else if (gwe) begin
      case (o_advance)
        2'd2:    r_cnt_dual   <= r_cnt_dual + 32'd1;
        2'd1:    r_cnt_single <= r_cnt_single + 32'd1;
        2'd0:    if (i_vld_A) r_cnt_stall <= r_cnt_stall + 32'd1;
        default: r_cnt_dual   <= r_cnt_dual;
      endcase
    end
  end

  assign o_cnt_dual   = r_cnt_dual;
  assign o_cnt_single = r_cnt_single;
  assign o_cnt_stall  = r_cnt_stall;
`endif

endmodule

// File: tb/tb_lc4_dual_issue_sched.sv
// Directed bench for lc4_dual_issue_sched: two instances (LOAD_LAT 1 and 2)
// share the stimulus; expected values are hand-computed per step.
module tb_lc4_dual_issue_sched;

  localparam logic [5:0] F_ALU = 6'b111000;
  localparam logic [5:0] F_LD  = 6'b110110;
  localparam logic [5:0] F_ST  = 6'b011100;
  localparam logic [5:0] F_BR  = 6'b010001;

  logic clk, rst, gwe, flush;
  logic vld_A, vld_B;
  logic [2:0] rs_A, rt_A, rd_A, rs_B, rt_B, rd_B;
  logic rs_re_A, rt_re_A, rd_we_A, rs_re_B, rt_re_B, rd_we_B;
  logic mem_A, ld_A, br_A, mem_B, ld_B, br_B;
  logic ia1, ib1, ia2, ib2;
  logic [1:0] adv1, cause1, adv2, cause2;

  int n_cmp = 0;
  int n_err = 0;

  lc4_dual_issue_sched #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .gwe(gwe), .i_flush(flush),
    .i_vld_A(vld_A), .i_vld_B(vld_B),
    .i_rs_A(rs_A), .i_rt_A(rt_A), .i_rd_A(rd_A),
    .i_rs_B(rs_B), .i_rt_B(rt_B), .i_rd_B(rd_B),
    .i_rs_re_A(rs_re_A), .i_rt_re_A(rt_re_A), .i_rd_we_A(rd_we_A),
    .i_rs_re_B(rs_re_B), .i_rt_re_B(rt_re_B), .i_rd_we_B(rd_we_B),
    .i_is_mem_A(mem_A), .i_is_load_A(ld_A), .i_is_br_A(br_A),
    .i_is_mem_B(mem_B), .i_is_load_B(ld_B), .i_is_br_B(br_B),
    .o_issue_A(ia1), .o_issue_B(ib1), .o_advance(adv1), .o_stall_cause(cause1)
  );

  lc4_dual_issue_sched #(.LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .gwe(gwe), .i_flush(flush),
    .i_vld_A(vld_A), .i_vld_B(vld_B),
    .i_rs_A(rs_A), .i_rt_A(rt_A), .i_rd_A(rd_A),
    .i_rs_B(rs_B), .i_rt_B(rt_B), .i_rd_B(rd_B),
    .i_rs_re_A(rs_re_A), .i_rt_re_A(rt_re_A), .i_rd_we_A(rd_we_A),
    .i_rs_re_B(rs_re_B), .i_rt_re_B(rt_re_B), .i_rd_we_B(rd_we_B),
    .i_is_mem_A(mem_A), .i_is_load_A(ld_A), .i_is_br_A(br_A),
    .i_is_mem_B(mem_B), .i_is_load_B(ld_B), .i_is_br_B(br_B),
    .o_issue_A(ia2), .o_issue_B(ib2), .o_advance(adv2), .o_stall_cause(cause2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic exp(input string tag, input int d, input logic ia, input logic ib,
                     input logic [1:0] adv, input logic [1:0] cause);
    if (d == 1) begin
      chk_eq({tag, ".d1.iA"}, 32'(ia1), 32'(ia));
      chk_eq({tag, ".d1.iB"}, 32'(ib1), 32'(ib));
      chk_eq({tag, ".d1.adv"}, 32'(adv1), 32'(adv));
      chk_eq({tag, ".d1.cause"}, 32'(cause1), 32'(cause));
    end else begin
      chk_eq({tag, ".d2.iA"}, 32'(ia2), 32'(ia));
      chk_eq({tag, ".d2.iB"}, 32'(ib2), 32'(ib));
      chk_eq({tag, ".d2.adv"}, 32'(adv2), 32'(adv));
      chk_eq({tag, ".d2.cause"}, 32'(cause2), 32'(cause));
    end
  endtask

  task automatic set_a(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt, input logic [5:0] f);
    vld_A = 1'b1; rd_A = rd; rs_A = rs; rt_A = rt;
    {rd_we_A, rs_re_A, rt_re_A, mem_A, ld_A, br_A} = f;
  endtask

  task automatic set_b(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt, input logic [5:0] f);
    vld_B = 1'b1; rd_B = rd; rs_B = rs; rt_B = rt;
    {rd_we_B, rs_re_B, rt_re_B, mem_B, ld_B, br_B} = f;
  endtask

  task automatic idle();
    gwe = 1'b1; flush = 1'b0;
    vld_A = 1'b0; rd_A = 3'd0; rs_A = 3'd0; rt_A = 3'd0;
    {rd_we_A, rs_re_A, rt_re_A, mem_A, ld_A, br_A} = 6'd0;
    vld_B = 1'b0; rd_B = 3'd0; rs_B = 3'd0; rt_B = 3'd0;
    {rd_we_B, rs_re_B, rt_re_B, mem_B, ld_B, br_B} = 6'd0;
  endtask

  // Advance one clock; inputs are re-driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    set_a(3'd1, 3'd2, 3'd3, F_ALU);
    set_b(3'd4, 3'd5, 3'd6, F_ALU);
    #3;
    exp("reset", 1, 1'b0, 1'b0, 2'd0, 2'd0);
    exp("reset", 2, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Independent ALU pair dual-issues on a clean scoreboard
    set_a(3'd1, 3'd2, 3'd3, F_ALU);
    set_b(3'd4, 3'd5, 3'd6, F_ALU);
    #2;
    exp("indep", 1, 1'b1, 1'b1, 2'd2, 2'd0);
    exp("indep", 2, 1'b1, 1'b1, 2'd2, 2'd0);
    step();

    set_a(3'd1, 3'd2, 3'd3, F_ALU);
    set_b(3'd4, 3'd1, 3'd6, F_ALU);
    #2;
    exp("raw_AB", 1, 1'b1, 1'b0, 2'd1, 2'd2);
    step();

    set_a(3'd0, 3'd1, 3'd2, F_ST);
    set_b(3'd0, 3'd5, 3'd6, F_ST);
    #2;
    exp("mem_mem", 1, 1'b1, 1'b0, 2'd1, 2'd3);
    step();

    set_a(3'd0, 3'd1, 3'd0, F_BR);
    set_b(3'd4, 3'd5, 3'd6, F_ALU);
    #2;
    exp("br_A", 2, 1'b1, 1'b0, 2'd1, 2'd3);
    step();

    set_a(3'd4, 3'd5, 3'd6, F_ALU);
    set_b(3'd4, 3'd2, 3'd3, F_ALU);
    #2;
    exp("waw", 1, 1'b1, 1'b1, 2'd2, 2'd0);
    step();

    // Load-use: load r3 then a reader of r3
    set_a(3'd3, 3'd2, 3'd0, F_LD);
    #2;
    exp("ld_N", 1, 1'b1, 1'b0, 2'd1, 2'd0);
    step();
    set_a(3'd1, 3'd3, 3'd4, F_ALU);
    #2;
    exp("ld_N1", 1, 1'b0, 1'b0, 2'd0, 2'd1);
    exp("ld_N1", 2, 1'b0, 1'b0, 2'd0, 2'd1);
    step();
    set_a(3'd1, 3'd3, 3'd4, F_ALU);
    #2;
    exp("ld_N2", 1, 1'b1, 1'b0, 2'd1, 2'd0);
    exp("ld_N2", 2, 1'b0, 1'b0, 2'd0, 2'd1);
    step();
    set_a(3'd1, 3'd3, 3'd4, F_ALU);
    #2;
    exp("ld_N3", 2, 1'b1, 1'b0, 2'd1, 2'd0);
    drain();

    // B both depends on A and hits the scoreboard: load-use wins
    set_a(3'd5, 3'd2, 3'd0, F_LD);
    step();
    set_a(3'd1, 3'd2, 3'd3, F_ALU);
    set_b(3'd4, 3'd1, 3'd5, F_ALU);
    #2;
    exp("B_prio", 1, 1'b1, 1'b0, 2'd1, 2'd1);
    drain();

    // Flush clears the scoreboard
    set_a(3'd2, 3'd1, 3'd0, F_LD);
    step();
    flush = 1'b1;
    set_a(3'd3, 3'd2, 3'd4, F_ALU);
    #2;
    chk_eq("flush.d1.iA", 32'(ia1), 32'd0);
    chk_eq("flush.d2.adv", 32'(adv2), 32'd0);
    step();
    set_a(3'd3, 3'd2, 3'd4, F_ALU);
    #2;
    exp("post_flush", 1, 1'b1, 1'b0, 2'd1, 2'd0);
    exp("post_flush", 2, 1'b1, 1'b0, 2'd1, 2'd0);
    drain();

    // gwe=0 freezes the scoreboard
    set_a(3'd6, 3'd1, 3'd0, F_LD);
    step();
    gwe = 1'b0;
    set_a(3'd1, 3'd6, 3'd2, F_ALU);
    #2;
    exp("gwe0", 1, 1'b0, 1'b0, 2'd0, 2'd1);
    step();
    set_a(3'd1, 3'd6, 3'd2, F_ALU);
    #2;
    exp("gwe_frozen", 1, 1'b0, 1'b0, 2'd0, 2'd1);
    step();
    set_a(3'd1, 3'd6, 3'd2, F_ALU);
    #2;
    exp("gwe_thaw", 1, 1'b1, 1'b0, 2'd1, 2'd0);
    exp("gwe_thaw", 2, 1'b0, 1'b0, 2'd0, 2'd1);
    drain();

    // Back-to-back loads to r3: new set overrides the decrement
    set_a(3'd3, 3'd1, 3'd0, F_LD);
    step();
    set_a(3'd3, 3'd1, 3'd0, F_LD);
    #2;
    chk_eq("reload.d1.iA", 32'(ia1), 32'd1);
    step();
    set_a(3'd1, 3'd3, 3'd2, F_ALU);
    #2;
    exp("override", 1, 1'b0, 1'b0, 2'd0, 2'd1);
    drain();

    // Asynchronous reset in the middle of a stall with busy[5]=2 in dut2
    set_a(3'd5, 3'd1, 3'd0, F_LD);
    step();
    set_a(3'd1, 3'd5, 3'd2, F_ALU);
    #2;
    exp("pre_rst", 2, 1'b0, 1'b0, 2'd0, 2'd1);
    rst = 1'b0;
    #1;
    exp("mid_rst", 1, 1'b0, 1'b0, 2'd0, 2'd0);
    exp("mid_rst", 2, 1'b0, 1'b0, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    exp("post_rst", 1, 1'b1, 1'b0, 2'd1, 2'd0);
    exp("post_rst", 2, 1'b1, 1'b0, 2'd1, 2'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc4_dual_issue_sched.md
LC4_DUAL_ISSUE_SCHED -- requirements
Module: lc4_dual_issue_sched

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, range 1..3: cycles a load's rd stays unreadable after issue.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port gwe  in  1  global write enable; no state changes when 0.
REQ-005 SHALL have port i_flush  in  1  squash: clears scoreboard, blocks issue this cycle.
REQ-006 SHALL have ports i_vld_A/i_vld_B  in  1  slot valid; A is older in program order.
REQ-007 SHALL have ports i_rs_A/i_rt_A/i_rd_A and i_rs_B/i_rt_B/i_rd_B  in  3  register selectors.
REQ-008 SHALL have ports i_rs_re_X, i_rt_re_X, i_rd_we_X (X = A, B)  in  1  read/write use flags.
REQ-009 SHALL have ports i_is_mem_X, i_is_load_X, i_is_br_X (X = A, B)  in  1  instruction class.
REQ-010 SHALL have ports o_issue_A/o_issue_B  out  1  slot issues this cycle.
REQ-011 SHALL have port o_advance  out  2  slots consumed (0, 1, 2) for fetch.
REQ-012 SHALL have port o_stall_cause  out  2  0 none, 1 load-use, 2 B-on-A dependence, 3 structural.

Function
REQ-013 SHALL keep a per-register busy counter busy[r] (2 bits, 8 entries) as the scoreboard.
REQ-014 Issue decisions SHALL be combinational from inputs and busy[]; busy[] SHALL update at clk edge when gwe=1.
REQ-015 A SHALL hazard if vld_A and any enabled A source r has busy[r] != 0.
REQ-016 o_issue_A SHALL = vld_A & !hazard_A & !i_flush.
REQ-017 B hazards: scoreboard hit as in REQ-015; enabled B source equals rd_A with rd_we_A; is_mem_A & is_mem_B; is_br_A.
REQ-018 o_issue_B SHALL = o_issue_A & vld_B & no B hazard; B never issues ahead of A.
REQ-019 Same-rd WAW between A and B SHALL NOT block B; the register file resolves it with B winning.
REQ-020 o_advance SHALL = o_issue_A + o_issue_B.
REQ-021 o_stall_cause SHALL report A's cause if A stalls, else B's; priority load-use > dependence > structural; 0 when both issue or both invalid.
REQ-022 Each edge: issued load with rd_we sets busy[rd] = LOAD_LAT; every other non-zero counter decrements by 1; zero saturates.
REQ-023 If A and B both issue loads to the same rd, busy[rd] SHALL = LOAD_LAT once (no double count).
REQ-024 Set SHALL override decrement on the same register in the same cycle.
REQ-025 i_flush=1 with gwe=1 SHALL zero all counters at the edge, regardless of issue.
REQ-026 gwe=0 SHALL freeze busy[]; outputs still reflect current inputs.

Reset
REQ-027 rst low SHALL immediately clear busy[] and optional counters, independent of clk/gwe.
REQ-028 During reset o_issue_A/B = 0, o_advance = 0, o_stall_cause = 0; first issue possible in the first cycle after release.

Configuration
REQ-029 Macro LC4_SS_PERF_CNT_EN, when defined, SHALL add 32-bit outputs o_cnt_dual, o_cnt_single, o_cnt_stall, counting gwe cycles with advance 2, 1, 0 (stall count only while vld_A=1), wrapping at 2^32.
REQ-030 Without LC4_SS_PERF_CNT_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Stall-cause encodings and the LOAD_LAT maximum SHALL live in shared package lc4_ss_pkg.
REQ-032 The hazard check for one slot SHALL be a sub-module lc4_hazard_chk, instantiated for A (scoreboard only) and B (full).

Verification
REQ-033 Independent ALU ops A: r1=r2+r3, B: r4=r5+r6, clean scoreboard -> issue_A=1, issue_B=1, advance=2, cause=0.
REQ-034 A writes r1, B reads r1 -> issue_A=1, issue_B=0, advance=1, cause=2.
REQ-035 LOAD_LAT=1: load r3 issues cycle N; cycle N+1 A reads r3 -> issue_A=0, cause=1; cycle N+2 -> issue_A=1.
REQ-036 A and B both memory ops -> advance=1, cause=3; A branch with independent B -> advance=1, cause=3.
REQ-037 Load r2 issues, then i_flush in next cycle -> no issue, busy[2]=0, reader of r2 issues the following cycle.
REQ-038 rst asserted mid-stall with busy[5]=2 -> outputs 0 at once; after release a reader of r5 issues immediately.
